sum_prod_seq: RTL and testbench
===============================

Name: sum_prod_seq

Overview:
- Sequential controller that computes the sum of pairwise products X[0]*X[1] + X[2]*X[3] + ... over one shared N-bit multiplier, one pair per clock.
- Replaces the fully parallel combinational sum_prod datapath where multiplier area matters.
- Input side and output side each use a valid/ready handshake, so the block can sit between pipeline stages.

Parameters:
- N, 4, operand width in bits (unsigned).
- PAIRS, 3, number of operand pairs; legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set on x is valid.
- in_ready  output  1  block can accept an operand set.
- x  input  N per element, unpacked [2*PAIRS-1:0]  operands; x[2i] and x[2i+1] form pair i.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- result  output  2*N+3  sum of products (11 bits at N=4).
- busy  output  1  high in CALC state.
- pair_idx  output  3  index of the pair being accumulated this cycle (debug).

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - result=0; pair_idx=0; accumulator and operand registers=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1, the block captures all 2*PAIRS operands into internal registers, clears acc to 0, sets pair_idx to 0 and moves to CALC.
  - If in_valid=0, the block stays in IDLE.
- CALC:
  - in_ready=0 and busy=1.
  - Each edge: acc <= acc + x_reg[2*pair_idx] * x_reg[2*pair_idx+1], then pair_idx increments.
  - On the edge that accumulates pair PAIRS-1, the block loads result with the final sum, sets pair_idx to 0 and moves to DONE.
  - Changes on x and in_valid during CALC or DONE are ignored. The captured copy is used.
- DONE:
  - out_valid=1; result holds steady.
  - On an edge with out_ready=1, the block drops out_valid and returns to IDLE.
  - While out_ready=0, the block holds DONE indefinitely and result stays stable.
  - No new input is accepted while in DONE.
- Latency:
  - Input accepted at edge k -> out_valid=1 after edge k+PAIRS.
  - Minimum cycle time per operation is PAIRS+2 edges (accept, PAIRS accumulates, handoff).
  - in_ready rises the cycle after the output handshake completes.
- Arithmetic:
  - All operands are unsigned.
  - Each product is 2N bits, zero-extended to 2N+3 before adding.
  - Width 2N+3 covers PAIRS<=8, so overflow is impossible. Maximum value is 8*(2^N-1)^2.
- result holds its last value from DONE until the next completion. It returns to 0 only on reset.
- PAIRS=1: CALC lasts one edge.
- Reset asserted mid-CALC or in DONE: the operation is aborted, no out_valid pulse occurs, and the block returns to IDLE with every reset value above.

Test Plan:
1. Basic run, N=4, PAIRS=3, out_ready=1:
   - Stimulus: one-cycle in_valid with x={3,2,4,1,7,5}.
   - Expect: busy=1 for 3 cycles, pair_idx stepping 0,1,2.
   - Expect: out_valid=1 with result=45 on the 3rd edge after accept, then back to IDLE with in_ready=1.
2. Maximum operands:
   - Stimulus: all x=15.
   - Expect: result=675 with no truncation.
   - Repeat with all x=0 and expect result=0.
3. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles after out_valid rises.
   - Expect: out_valid stays 1 and result stays 45 throughout. in_ready=0 and in_valid pulses are ignored.
   - Then raise out_ready: the block returns to IDLE on that edge.
4. Input isolation:
   - Stimulus: after accepting {1,1,1,1,1,1}, drive x={15,...} with in_valid=1 during CALC.
   - Expect: result=3, and the second set is not accepted until IDLE.
5. Back-to-back:
   - Stimulus: hold in_valid=1 with out_ready=1 and operand sets A={3,2,4,1,7,5} then B={2,2,2,2,2,2}.
   - Expect: results 45 then 12.
   - Expect: second accept occurs exactly one cycle after A's output handshake.
6. Reset mid-operation:
   - Stimulus: drop rst_n between clock edges during the 2nd CALC cycle.
   - Expect: outputs go to reset values immediately and no out_valid pulse appears.
   - After release, a fresh run of {3,2,4,1,7,5} gives 45.

Source files
------------

// File: rtl/sum_prod_seq.sv
// -----------------------------------------------------------------------------
// sum_prod_seq
//
// Sequential sum of pairwise products:
//   result = x[0]*x[1] + x[2]*x[3] + ... + x[2*PAIRS-2]*x[2*PAIRS-1]
// One unsigned N x N multiplier is shared across the pairs, and one pair is
// accumulated per clock. The input and output sides each use a valid/ready
// handshake so the block can sit between pipeline stages.
//
// Parameters:
//   N      operand width in bits (unsigned)
//   PAIRS  number of operand pairs (1..8)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set on x is valid
//   in_ready   block can accept an operand set (IDLE)
//   x          2*PAIRS operands; x[2i] and x[2i+1] form pair i
//   out_valid  result is valid (DONE)
//   out_ready  downstream accepts the result
//   result     sum of products, 2N+3 bits; holds until the next completion
//   busy       high while accumulating (CALC)
//   pair_idx   index of the pair accumulated this cycle (debug)
// -----------------------------------------------------------------------------
module sum_prod_seq #(
    parameter int N     = 4,
    parameter int PAIRS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x [2*PAIRS-1:0],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N+2:0]   result,
    output logic             busy,
    output logic [2:0]       pair_idx
);

    localparam int         RW       = 2 * N + 3;
    localparam int         NOPS     = 2 * PAIRS;
    localparam logic [2:0] LAST_IDX = 3'(PAIRS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0]    x_reg [NOPS-1:0];
    logic [RW-1:0]   acc;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [2*N-1:0]  prod;
    logic [RW-1:0]   acc_next;
    logic            last_pair;

    // -------------------------------------------------------------------------
    // Operand select for the shared multiplier: pick the captured pair that
    // pair_idx points at. Indices beyond PAIRS-1 never occur; they read 0.
    // -------------------------------------------------------------------------
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int unsigned i = 0; i < PAIRS; i++) begin
            if (pair_idx == 3'(i)) begin
                op_a = x_reg[2*i];
                op_b = x_reg[2*i+1];
            end
        end
    end

    // Both operands are zero-extended so the product is a full 2N bits, and
    // the product is zero-extended again to the 2N+3 accumulator width.
    always_comb begin
        prod      = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};
        acc_next  = acc + {3'b000, prod};
        last_pair = (pair_idx == LAST_IDX);
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_pair) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from state only)
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            CALC:    busy      = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: operand capture, accumulation, result register.
    // x and in_valid are only sampled in IDLE; CALC works from x_reg alone.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            result   <= '0;
            pair_idx <= '0;
            for (int unsigned i = 0; i < NOPS; i++) begin
                x_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < NOPS; i++) begin
                            x_reg[i] <= x[i];
                        end
                        acc      <= '0;
                        pair_idx <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    if (last_pair) begin
                        // Final sum goes straight to result on the same edge.
                        result   <= acc_next;
                        pair_idx <= '0;
                    end else begin
                        pair_idx <= pair_idx + 3'd1;
                    end
                end
                default: begin
                    // DONE: result holds; nothing else changes.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_prod_seq.sv
module tb_sum_prod_seq;

    localparam int N     = 4;
    localparam int PAIRS = 3;
    localparam int NOPS  = 2 * PAIRS;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     x [NOPS-1:0];
    logic             out_valid;
    logic             out_ready;
    logic [2*N+2:0]   result;
    logic             busy;
    logic [2:0]       pair_idx;

    int total;
    int bad;

    sum_prod_seq #(.N(N), .PAIRS(PAIRS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy),
        .pair_idx  (pair_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int a0, input int a1, input int a2,
                         input int a3, input int a4, input int a5);
        x[0] = 4'(a0); x[1] = 4'(a1); x[2] = 4'(a2);
        x[3] = 4'(a3); x[4] = 4'(a4); x[5] = 4'(a5);
    endtask

    // Accept one set with out_ready=1, walk CALC, check result and return.
    task automatic run_op(input string tag, input int expected);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();                      // accept edge
        in_valid = 1'b0;
        for (int i = 0; i < PAIRS; i++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_idx"}, 32'(pair_idx), 32'(i));
            tick();
        end
        check({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(expected));
        tick();                      // output handshake
        check({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_iready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_x(0, 0, 0, 0, 0, 0);

        // Reset state
        tick();
        tick();
        check("rst_iready", 32'(in_ready), 32'd1);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_idx", 32'(pair_idx), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_hold", 32'(in_ready), 32'd1);

        // 1: basic run, 6+4+35
        set_x(3, 2, 4, 1, 7, 5);
        run_op("basic", 45);

        // 2: maximum and zero operands
        set_x(15, 15, 15, 15, 15, 15);
        run_op("max", 675);
        set_x(0, 0, 0, 0, 0, 0);
        run_op("zero", 0);

        // 3: backpressure
        set_x(3, 2, 4, 1, 7, 5);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("bp_ovalid_rise", 32'(out_valid), 32'd1);
        set_x(15, 15, 15, 15, 15, 15);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            check("bp_ovalid", 32'(out_valid), 32'd1);
            check("bp_result", 32'(result), 32'd45);
            check("bp_iready", 32'(in_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_ovalid", 32'(out_valid), 32'd0);
        check("bp_release_iready", 32'(in_ready), 32'd1);
        check("bp_result_hold", 32'(result), 32'd45);

        // 4: input isolation
        set_x(1, 1, 1, 1, 1, 1);
        in_valid = 1'b1;
        tick();
        set_x(15, 15, 15, 15, 15, 15);
        tick();
        check("iso_iready_calc", 32'(in_ready), 32'd0);
        tick();
        tick();
        check("iso_result", 32'(result), 32'd3);
        check("iso_ovalid", 32'(out_valid), 32'd1);
        tick();                      // handshake; second set still pending
        check("iso_idle_iready", 32'(in_ready), 32'd1);
        check("iso_idle_busy", 32'(busy), 32'd0);
        tick();                      // second set accepted only now
        in_valid = 1'b0;
        check("iso_second_busy", 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        check("iso_second_result", 32'(result), 32'd675);
        tick();

        // 5: back-to-back, in_valid held high
        set_x(3, 2, 4, 1, 7, 5);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();                      // accept A
        set_x(2, 2, 2, 2, 2, 2);
        tick();
        tick();
        tick();
        check("b2b_a_ovalid", 32'(out_valid), 32'd1);
        check("b2b_a_result", 32'(result), 32'd45);
        tick();                      // A handshake
        check("b2b_gap_iready", 32'(in_ready), 32'd1);
        check("b2b_gap_busy", 32'(busy), 32'd0);
        tick();                      // B accepted one cycle after handshake
        in_valid = 1'b0;
        check("b2b_b_busy", 32'(busy), 32'd1);
        check("b2b_b_idx", 32'(pair_idx), 32'd0);
        tick();
        tick();
        tick();
        check("b2b_b_ovalid", 32'(out_valid), 32'd1);
        check("b2b_b_result", 32'(result), 32'd12);
        tick();

        // 6: reset during the 2nd CALC cycle
        set_x(3, 2, 4, 1, 7, 5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_idx", 32'(pair_idx), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_iready", 32'(in_ready), 32'd1);
        check("mid_rst_ovalid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_idx", 32'(pair_idx), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_pulse", 32'(out_valid), 32'd0);
        end
        run_op("post_rst", 45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
